// File: rtl/alu_flag_branch_unit.sv
// Architectural Z/N/C/V flag register with a save/restore stack, plus a
// one-stage valid/ready branch resolver that evaluates against bypassed flags.
module alu_flag_branch_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       status_in,
    input  logic              flag_we,
    input  logic              flag_push,
    input  logic              flag_pop,
    input  logic              cond_valid,
    output logic              cond_ready,
    input  logic [2:0]        cond_code,
    input  logic [ADDR_W-1:0] cond_target,
    output logic              br_valid,
    input  logic              br_ready,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target,
    output logic [15:0]       flags_out,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STACK_DEPTH);

    // Flag nibble order is {Z, N, C, V}.
    logic [3:0]        flags_q, flags_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              err_q, err_d;
    logic              br_valid_q, br_valid_d;
    logic              br_taken_q, br_taken_d;
    logic [ADDR_W-1:0] br_target_q, br_target_d;
    logic [3:0]        stack_mem [STACK_DEPTH];

    logic              push_ok, pop_ok;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic [PTR_W-1:0]  ptr_dec;
    logic              cond_true;
    logic              accept;

    assign stack_empty = (ptr_q == '0);
    assign stack_full  = (ptr_q == PTR_FULL);
    assign ptr_dec     = ptr_q - PTR_ONE;
    assign push_idx    = ptr_q[IDX_W-1:0];
    assign pop_idx     = ptr_dec[IDX_W-1:0];

    // Simultaneous push and pop cancel each other and count as an error.
    assign push_ok = flag_push && !flag_pop && !stack_full;
    assign pop_ok  = flag_pop && !flag_push && !stack_empty;

    always_comb begin
        flags_d = flags_q;
        ptr_d   = ptr_q;
        err_d   = (flag_push && flag_pop)
                || (flag_push && !flag_pop && stack_full)
                || (flag_pop && !flag_push && stack_empty);
        if (pop_ok) begin
            flags_d = stack_mem[pop_idx];
            ptr_d   = ptr_dec;
        end else begin
            if (flag_we) begin
                flags_d = status_in[15:12];
            end
            if (push_ok) begin
                ptr_d = ptr_q + PTR_ONE;
            end
        end
    end

    // Conditions see this cycle's next-flags value so a request issued
    // alongside a flag write or pop resolves against the new flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond_code)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_d[3];
            3'b010:  cond_true = !flags_d[3];
            3'b011:  cond_true = flags_d[2];
            3'b100:  cond_true = !flags_d[2];
            3'b101:  cond_true = flags_d[1];
            3'b110:  cond_true = flags_d[0];
            default: cond_true = 1'b0;
        endcase
    end

    assign cond_ready = !br_valid_q || br_ready;
    assign accept     = cond_valid && cond_ready;

    always_comb begin
        br_valid_d  = br_valid_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        if (accept) begin
            br_valid_d  = 1'b1;
            br_taken_d  = cond_true;
            br_target_d = cond_target;
        end else if (br_ready) begin
            br_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            br_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            flags_q     <= flags_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            br_valid_q  <= br_valid_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    // Stack storage is left unreset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            stack_mem[push_idx] <= flags_q;
        end
    end

    assign flags_out = {flags_q, 12'b0};
    assign stack_err = err_q;
    assign br_valid  = br_valid_q;
    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Directed table of per-cycle stimulus with hand-computed results, followed by
// hand-written sequences for combinational ready and result hold under stall.
module tb_alu_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst, flag_we, flag_push, flag_pop, cond_valid, br_ready;
    logic [15:0] status_in, cond_target;
    logic [2:0]  cond_code;
    logic        cond_ready, br_valid, br_taken, stack_empty, stack_full, stack_err;
    logic [15:0] br_target, flags_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_flag_branch_unit #(.STACK_DEPTH(4), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .status_in(status_in), .flag_we(flag_we),
        .flag_push(flag_push), .flag_pop(flag_pop), .cond_valid(cond_valid),
        .cond_ready(cond_ready), .cond_code(cond_code), .cond_target(cond_target),
        .br_valid(br_valid), .br_ready(br_ready), .br_taken(br_taken),
        .br_target(br_target), .flags_out(flags_out), .stack_empty(stack_empty),
        .stack_full(stack_full), .stack_err(stack_err)
    );

    typedef struct {
        logic        rst, we;
        logic [3:0]  st;
        logic        push, pop, cv;
        logic [2:0]  cc;
        logic [15:0] tgt;
        logic        brr;
        logic [3:0]  fl;
        logic        bv, bt;
        logic [15:0] btg;
        logic        emp, ful, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic we, input logic [3:0] st,
                       input logic push, input logic pop, input logic cv,
                       input logic [2:0] cc, input logic [15:0] tgt, input logic brr,
                       input logic [3:0] fl, input logic bv, input logic bt,
                       input logic [15:0] btg, input logic emp, input logic ful,
                       input logic err);
        vec_t v;
        v = '{r, we, st, push, pop, cv, cc, tgt, brr, fl, bv, bt, btg, emp, ful, err};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0; flag_we = 1'b0; flag_push = 1'b0; flag_pop = 1'b0;
        cond_valid = 1'b0; br_ready = 1'b1; status_in = '0; cond_code = '0;
        cond_target = '0;

        //   rst we st  pu po cv cc  tgt      brr  fl  bv bt btg      emp ful err
        add(1, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 1, 4'h8, 0, 0, 0, 0, 16'h0000, 1, 4'h8, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 1, 16'h0040, 1, 4'h8, 1, 1, 16'h0040, 1, 0, 0);
        add(0, 1, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 0, 1, 16'h0040, 1, 0, 0);
        add(0, 1, 4'h4, 0, 0, 1, 3, 16'h0100, 1, 4'h4, 1, 1, 16'h0100, 1, 0, 0);
        add(0, 1, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 0, 1, 16'h0100, 1, 0, 0);
        add(0, 1, 4'h4, 0, 0, 1, 4, 16'h0108, 1, 4'h4, 1, 0, 16'h0108, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 4'h0, 0, 0, 1, 0, 16'h0200, 0, 4'h4, 1, 0, 16'h0108, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 0, 16'h0200, 1, 4'h4, 1, 1, 16'h0200, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 7, 16'h0204, 1, 4'h4, 1, 0, 16'h0204, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 2, 16'h0208, 1, 4'h4, 1, 1, 16'h0208, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 4'h4, 0, 1, 16'h0208, 1, 0, 0);
        add(0, 1, 4'h2, 0, 0, 1, 5, 16'h0300, 1, 4'h2, 1, 1, 16'h0300, 1, 0, 0);
        add(0, 1, 4'h1, 0, 0, 1, 6, 16'h0304, 1, 4'h1, 1, 1, 16'h0304, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 5, 16'h0308, 1, 4'h1, 1, 0, 16'h0308, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0, 1, 3, 16'h030C, 1, 4'h1, 1, 0, 16'h030C, 1, 0, 0);
        // Stack fill: each push stores the flags registered before the write.
        add(0, 1, 4'h2, 1, 0, 0, 0, 16'h0000, 1, 4'h2, 0, 0, 16'h030C, 0, 0, 0);
        add(0, 1, 4'h4, 1, 0, 0, 0, 16'h0000, 1, 4'h4, 0, 0, 16'h030C, 0, 0, 0);
        add(0, 1, 4'h8, 1, 0, 0, 0, 16'h0000, 1, 4'h8, 0, 0, 16'h030C, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 0, 0, 16'h0000, 1, 4'h8, 0, 0, 16'h030C, 0, 1, 0);
        add(0, 1, 4'h3, 1, 0, 0, 0, 16'h0000, 1, 4'h3, 0, 0, 16'h030C, 0, 1, 1);
        add(0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 4'h3, 0, 0, 16'h030C, 0, 1, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 16'h0000, 1, 4'h8, 0, 0, 16'h030C, 0, 0, 0);
        add(0, 1, 4'hF, 0, 1, 0, 0, 16'h0000, 1, 4'h4, 0, 0, 16'h030C, 0, 0, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 16'h0000, 1, 4'h2, 0, 0, 16'h030C, 0, 0, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 16'h0000, 1, 4'h1, 0, 0, 16'h030C, 1, 0, 0);
        add(0, 1, 4'h6, 0, 1, 0, 0, 16'h0000, 1, 4'h6, 0, 0, 16'h030C, 1, 0, 1);
        add(0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 1, 4'h6, 0, 0, 16'h030C, 1, 0, 0);
        add(0, 0, 4'h0, 1, 0, 0, 0, 16'h0000, 1, 4'h6, 0, 0, 16'h030C, 0, 0, 0);
        add(0, 1, 4'h9, 1, 1, 0, 0, 16'h0000, 1, 4'h9, 0, 0, 16'h030C, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 3, 16'h0400, 1, 4'h6, 1, 1, 16'h0400, 1, 0, 0);
        // Mid-operation reset with a pending result and two stack entries.
        add(0, 1, 4'hF, 1, 0, 0, 0, 16'h0000, 1, 4'hF, 0, 1, 16'h0400, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0, 1, 0, 16'h0500, 0, 4'hF, 1, 1, 16'h0500, 0, 0, 0);
        add(1, 0, 4'h0, 0, 0, 1, 0, 16'h0600, 0, 4'h0, 0, 0, 16'h0000, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            flag_we    = vecs[i].we;
            status_in  = {vecs[i].st, 12'hA5C};
            flag_push  = vecs[i].push;
            flag_pop   = vecs[i].pop;
            cond_valid = vecs[i].cv;
            cond_code  = vecs[i].cc;
            cond_target = vecs[i].tgt;
            br_ready   = vecs[i].brr;
            @(posedge clk);
            #1;
            chk("flags_out",   i, 32'(flags_out),   32'({vecs[i].fl, 12'h000}));
            chk("br_valid",    i, 32'(br_valid),    32'(vecs[i].bv));
            chk("br_taken",    i, 32'(br_taken),    32'(vecs[i].bt));
            chk("br_target",   i, 32'(br_target),   32'(vecs[i].btg));
            chk("stack_empty", i, 32'(stack_empty), 32'(vecs[i].emp));
            chk("stack_full",  i, 32'(stack_full),  32'(vecs[i].ful));
            chk("stack_err",   i, 32'(stack_err),   32'(vecs[i].err));
            chk("cond_ready",  i, 32'(cond_ready),  32'(!vecs[i].bv || vecs[i].brr));
            $display("step %0d: flags=%h bv=%0b bt=%0b tgt=%h emp=%0b full=%0b err=%0b rdy=%0b",
                     i, flags_out, br_valid, br_taken, br_target, stack_empty,
                     stack_full, stack_err, cond_ready);
        end

        // Stalled result holds while further requests wait; ready follows br_ready combinationally.
        rst = 1'b0; flag_we = 1'b0; flag_push = 1'b0; flag_pop = 1'b0;
        cond_valid = 1'b1; cond_code = 3'b000; cond_target = 16'h0700; br_ready = 1'b0;
        @(posedge clk); #1;
        chk("hold_valid", 100, 32'(br_valid), 32'd1);
        chk("hold_ready", 100, 32'(cond_ready), 32'd0);
        cond_code = 3'b111; cond_target = 16'h0704;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("hold_target", 101 + k, 32'(br_target), 32'h0700);
            chk("hold_taken",  101 + k, 32'(br_taken),  32'd1);
        end
        br_ready = 1'b1;
        #1;
        chk("comb_ready", 103, 32'(cond_ready), 32'd1);
        @(posedge clk); #1;
        chk("replace_target", 104, 32'(br_target), 32'h0704);
        chk("replace_taken",  104, 32'(br_taken),  32'd0);
        chk("replace_valid",  104, 32'(br_valid),  32'd1);
        $display("stall sequence: target=%h taken=%0b valid=%0b", br_target, br_taken, br_valid);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
